// File: rtl/traffic_pkg.sv
// Shared definitions for the 4-way traffic light FSM and its request scheduler.
// One-hot direction bit order is A=bit3 .. D=bit0 everywhere.
package traffic_pkg;

    typedef enum logic [1:0] {
        DIR_A = 2'd0,
        DIR_B = 2'd1,
        DIR_C = 2'd2,
        DIR_D = 2'd3
    } dir_t;

    localparam logic [3:0] LIGHT_A = 4'b1000;
    localparam logic [3:0] LIGHT_B = 4'b0100;
    localparam logic [3:0] LIGHT_C = 4'b0010;
    localparam logic [3:0] LIGHT_D = 4'b0001;

    // Dwell times used by the light FSM.
    localparam int GREEN_DWELL  = 16;
    localparam int YELLOW_DWELL = 4;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_REQUEST = 1'b1
    } sched_state_t;

    // Round-robin successor of a one-hot direction: A->B->C->D->A.
    function automatic logic [3:0] rr_next(input logic [3:0] dir);
        return {dir[0], dir[3:1]};
    endfunction

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
    endfunction

    function automatic logic [3:0] dir_to_light(input dir_t d);
        return LIGHT_A >> d;
    endfunction

endpackage

// File: rtl/traffic_rr_pick.sv
// Combinational round-robin picker: first set bit of cand_i found by walking
// A->B->C->D->A starting at (and including) the one-hot start_i.
module traffic_rr_pick
    import traffic_pkg::*;
(
    input  logic [3:0] cand_i,
    input  logic [3:0] start_i,
    output logic [3:0] winner_o
);

    logic [3:0] probe;
    logic       found;

    always_comb begin
        winner_o = 4'b0000;
        found    = 1'b0;
        probe    = start_i;
        for (int k = 0; k < 4; k++) begin
            if (!found && ((cand_i & probe) != 4'b0000)) begin
                winner_o = probe;
                found    = 1'b1;
            end
            probe = rr_next(probe);
        end
    end

endmodule

// File: rtl/traffic_request_scheduler.sv
// Latches car-sensor requests, ages them, and drives one switch_to line at a
// time toward the light FSM until it shows that direction green.
module traffic_request_scheduler
    import traffic_pkg::*;
#(
    parameter logic [7:0] MAX_WAIT = 8'd32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req_sense,
    input  logic [3:0] light_en,
    output logic       switch_to_a,
    output logic       switch_to_b,
    output logic       switch_to_c,
    output logic       switch_to_d,
    output logic [3:0] pending,
    output logic [3:0] urgent
);

    sched_state_t state_q, state_d;
    logic [3:0]   pending_q, pending_d;
    logic [3:0]   urgent_q, urgent_d;
    logic [3:0]   switch_q, switch_d;
    logic [3:0]   target_q, target_d;
    logic [3:0]   cur_q, cur_d;
    logic [3:0]   ack_clr;
    logic [7:0]   wait_q [4];
    logic [7:0]   wait_d [4];

    logic         cur_valid;
    logic [3:0]   cand, urg_cand, rr_start, win_urg, win_all, pick;

    assign cur_valid = is_onehot(light_en);
    assign cand      = pending_q & ~light_en;
    assign urg_cand  = cand & urgent_q;
    assign rr_start  = rr_next(light_en);

    traffic_rr_pick u_pick_urg (
        .cand_i   (urg_cand),
        .start_i  (rr_start),
        .winner_o (win_urg)
    );

    traffic_rr_pick u_pick_all (
        .cand_i   (cand),
        .start_i  (rr_start),
        .winner_o (win_all)
    );

    assign pick = (urg_cand != 4'b0000) ? win_urg : win_all;

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        cur_d    = cur_q;
        switch_d = 4'b0000;
        ack_clr  = 4'b0000;
        case (state_q)
            ST_IDLE: begin
                if (cur_valid && (cand != 4'b0000)) begin
                    state_d  = ST_REQUEST;
                    target_d = pick;
                    cur_d    = light_en;
                    switch_d = pick;
                end
            end
            ST_REQUEST: begin
                if (light_en == target_q) begin
                    state_d = ST_IDLE;
                    ack_clr = target_q;
                end else if (!cur_valid || (light_en != cur_q)) begin
                    // Light moved somewhere else or went dark: give up, keep the request.
                    state_d = ST_IDLE;
                end else begin
                    switch_d = target_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign pending_d = (pending_q | req_sense) & ~light_en & ~ack_clr;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            wait_d[i] = 8'd0;
            if (pending_d[i] && pending_q[i]) begin
                wait_d[i] = (wait_q[i] == 8'hFF) ? wait_q[i] : wait_q[i] + 8'd1;
            end
            urgent_d[i] = pending_d[i] && (wait_d[i] >= MAX_WAIT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pending_q <= 4'b0000;
            urgent_q  <= 4'b0000;
            switch_q  <= 4'b0000;
            target_q  <= 4'b0000;
            cur_q     <= 4'b0000;
            for (int i = 0; i < 4; i++) wait_q[i] <= 8'd0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            urgent_q  <= urgent_d;
            switch_q  <= switch_d;
            target_q  <= target_d;
            cur_q     <= cur_d;
            for (int i = 0; i < 4; i++) wait_q[i] <= wait_d[i];
        end
    end

    assign switch_to_a = |(switch_q & LIGHT_A);
    assign switch_to_b = |(switch_q & LIGHT_B);
    assign switch_to_c = |(switch_q & LIGHT_C);
    assign switch_to_d = |(switch_q & LIGHT_D);
    assign pending     = pending_q;
    assign urgent      = urgent_q;

endmodule
